// File: rtl/disp_pkg.sv
// Shared definitions for the display pattern generator: pattern mode
// encodings and the colour-bar palette.
package disp_pkg;

    typedef enum logic [1:0] {
        PAT_BARS   = 2'd0,
        PAT_GRID   = 2'd1,
        PAT_GRAD   = 2'd2,
        PAT_SCROLL = 2'd3
    } pat_mode_t;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    // Bar order, left to right: classic SMPTE-style descending luminance.
    localparam logic [23:0] BAR_RGB [8] = '{
        COL_WHITE, COL_YELLOW, COL_CYAN, COL_GREEN,
        COL_MAGENTA, COL_RED, COL_BLUE, COL_BLACK
    };

endpackage

// File: rtl/disp_colorbar.sv
// Combinational lookup from bar index to 24-bit RGB colour.
module disp_colorbar (
    input  logic [2:0]  bar_idx,
    output logic [23:0] rgb
);
    import disp_pkg::*;

    // Plain palette lookup; no state.
    always_comb begin
        rgb = BAR_RGB[bar_idx];
    end

endmodule

// File: rtl/disp_patgen.sv
// Test-pattern generator sitting behind an external video timing generator.
// Timing signals pass through a two-register pipeline; the colour is computed
// from stage-0 state so RGB lines up with the delayed timing outputs.
module disp_patgen #(
    parameter logic [15:0] HOR_ADDR = 16'd640,
    parameter logic [15:0] VER_ADDR = 16'd480,
    parameter logic [15:0] BAR_W    = 16'd80
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HSYNC_N_IN,
    input  logic       VSYNC_N_IN,
    input  logic       BLANK_N_IN,
    input  logic [1:0] MODE,
    output logic       HSYNC_N,
    output logic       VSYNC_N,
    output logic       BLANK_N,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       FRAME_START
);
    import disp_pkg::*;

    logic        hs_s0_reg, vs_s0_reg, bl_s0_reg;
    logic [1:0]  mode_s0_reg;
    logic [11:0] x_reg, y_reg;
    logic [15:0] bar_cnt_reg;
    logic [2:0]  bar_idx_reg;
    logic [7:0]  frame_reg;
    pat_mode_t   mode_reg;
    logic        vs_fall, bl_fall;
    logic [23:0] bar_rgb, pix_rgb;
    logic [11:0] scroll_sum;

    // The output-stage timing registers hold the previous stage-0 value,
    // so they double as the "last cycle" reference for edge detection.
    assign vs_fall = VSYNC_N & ~vs_s0_reg;
    assign bl_fall = BLANK_N & ~bl_s0_reg;

    // Stage 0: register every input once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hs_s0_reg   <= 1'b0;
            vs_s0_reg   <= 1'b0;
            bl_s0_reg   <= 1'b0;
            mode_s0_reg <= 2'd0;
        end else begin
            hs_s0_reg   <= HSYNC_N_IN;
            vs_s0_reg   <= VSYNC_N_IN;
            bl_s0_reg   <= BLANK_N_IN;
            mode_s0_reg <= MODE;
        end
    end

    // Horizontal position and bar tracking; both restart on every blank.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_reg       <= 12'd0;
            bar_cnt_reg <= 16'd0;
            bar_idx_reg <= 3'd0;
        end else if (!bl_s0_reg) begin
            x_reg       <= 12'd0;
            bar_cnt_reg <= 16'd0;
            bar_idx_reg <= 3'd0;
        end else begin
            if (x_reg != 12'hFFF)
                x_reg <= x_reg + 12'd1;
            if (bar_cnt_reg == BAR_W - 16'd1) begin
                bar_cnt_reg <= 16'd0;
                if (bar_idx_reg != 3'd7)
                    bar_idx_reg <= bar_idx_reg + 3'd1;
            end else begin
                bar_cnt_reg <= bar_cnt_reg + 16'd1;
            end
        end
    end

    // Line counter: vsync clear has priority over the end-of-line increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            y_reg <= 12'd0;
        else if (vs_fall)
            y_reg <= 12'd0;
        else if (bl_fall && y_reg != 12'hFFF)
            y_reg <= y_reg + 12'd1;
    end

    // Per-frame state: frame number and the pattern latched for this frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_reg <= 8'd0;
            mode_reg  <= PAT_BARS;
        end else if (vs_fall) begin
            frame_reg <= frame_reg + 8'd1;
            mode_reg  <= pat_mode_t'(mode_s0_reg);
        end
    end

    disp_colorbar u_colorbar (
        .bar_idx (bar_idx_reg),
        .rgb     (bar_rgb)
    );

    // Pattern colour for the pixel currently held in stage 0.
    always_comb begin
        pix_rgb    = COL_BLACK;
        scroll_sum = x_reg + {4'd0, frame_reg};
        case (mode_reg)
            PAT_BARS: pix_rgb = bar_rgb;
            PAT_GRID: begin
                if (x_reg[4:0] == 5'd0 || y_reg[4:0] == 5'd0 ||
                    {4'd0, x_reg} == HOR_ADDR - 16'd1 ||
                    {4'd0, y_reg} == VER_ADDR - 16'd1)
                    pix_rgb = COL_WHITE;
            end
            PAT_GRAD:   pix_rgb = {x_reg[7:0], y_reg[7:0], frame_reg};
            PAT_SCROLL: begin
                if (scroll_sum[5] ^ y_reg[5])
                    pix_rgb = COL_WHITE;
            end
            default: pix_rgb = COL_BLACK;
        endcase
    end

    // Stage 1: registered outputs; colour forced black outside active video.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            HSYNC_N     <= 1'b0;
            VSYNC_N     <= 1'b0;
            BLANK_N     <= 1'b0;
            R           <= 8'd0;
            G           <= 8'd0;
            B           <= 8'd0;
            FRAME_START <= 1'b0;
        end else begin
            HSYNC_N     <= hs_s0_reg;
            VSYNC_N     <= vs_s0_reg;
            BLANK_N     <= bl_s0_reg;
            R           <= bl_s0_reg ? pix_rgb[23:16] : 8'd0;
            G           <= bl_s0_reg ? pix_rgb[15:8]  : 8'd0;
            B           <= bl_s0_reg ? pix_rgb[7:0]   : 8'd0;
            FRAME_START <= vs_fall;
        end
    end

endmodule
